parity_serializer: RTL and testbench

Parametrised parity generator and serializer; generalises the 4-bit combinational even-parity generator.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Computes even or odd parity per word.
- Shifts the word out LSB-first, followed by the parity bit, on a one-bit serial line.
- Sits between a word producer and a serial link or UART-style framer; also keeps a wrapping frame counter for debug.

---
 rtl/parity_serializer.sv | 144 ++++++++++++++
 tb/tb_parity_serializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_serializer.sv
// Parity generator and serializer.
// Takes DATA_W-bit words over a valid/ready handshake, computes even or odd
// parity, and shifts the word out LSB-first followed by the parity bit.
// A wrapping frame counter tracks completed frames for debug.
module parity_serializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              odd_mode,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              parity_out,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              parity_q, parity_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ser_out_q, ser_out_d;
    logic ser_valid_q, ser_valid_d;
    logic frame_start_q, frame_start_d;
    logic frame_end_q, frame_end_d;
    logic in_ready_q, in_ready_d;
    logic busy_q, busy_d;

    logic accept;

    // in_ready is registered, so acceptance depends on no combinational input path
    assign accept = in_valid && in_ready_q;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SHIFT;
                    shreg_d  = in_data;
                    idx_d    = '0;
                    parity_d = (^in_data) ^ odd_mode;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = PARITY;
                    idx_d   = '0;
                end
            end
            PARITY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (accept) begin
                    state_d  = SHIFT;
                    shreg_d  = in_data;
                    idx_d    = '0;
                    parity_d = (^in_data) ^ odd_mode;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next state so they can be registered
        // while still matching the decode of the state they accompany.
        ser_valid_d   = (state_d != IDLE);
        busy_d        = (state_d != IDLE);
        in_ready_d    = (state_d != SHIFT);
        frame_start_d = (state_d == SHIFT) && (idx_d == '0);
        frame_end_d   = (state_d == PARITY);
        if (state_d == SHIFT) begin
            ser_out_d = shreg_d[0];
        end else if (state_d == PARITY) begin
            ser_out_d = parity_d;
        end else begin
            ser_out_d = 1'b0;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            idx_q         <= '0;
            parity_q      <= 1'b0;
            cnt_q         <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            idx_q         <= idx_d;
            parity_q      <= parity_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign parity_out  = parity_q;
    assign busy        = busy_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Scoreboard bench for parity_serializer (DATA_W=8, CNT_W=2).
// Driver pushes the expected frame on acceptance; monitor checks every
// serial bit, frame markers, parity_out and the wrapping frame counter.
module tb_parity_serializer;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
    } frame_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          odd_mode;
    logic          ser_out;
    logic          ser_valid;
    logic          frame_start;
    logic          frame_end;
    logic          parity_out;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    frame_t sb[$];
    int     n_pass  = 0;
    int     n_total = 0;

    // monitor state
    int          bit_i       = 0;
    logic [CW-1:0] exp_cnt   = '0;
    bit          cnt_pending = 0;
    bit          abort_req   = 0;
    int          run_len     = 0;
    int          last_run    = 0;

    parity_serializer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .odd_mode   (odd_mode),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .parity_out (parity_out),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (abort_req) begin
                if (sb.size() > 0) void'(sb.pop_front());
                bit_i       = 0;
                exp_cnt     = '0;
                cnt_pending = 0;
                abort_req   = 0;
            end
            if (cnt_pending) begin
                chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
                cnt_pending = 0;
            end
            if (ser_valid) begin
                run_len++;
                if (sb.size() == 0) begin
                    chk("unexpected_ser_valid", 32'(ser_valid), 32'd0);
                end else if (bit_i < int'(DW)) begin
                    chk("data_bit", 32'(ser_out), 32'(sb[0].data[bit_i]));
                    chk("frame_start", 32'(frame_start), 32'(bit_i == 0));
                    chk("frame_end_in_data", 32'(frame_end), 32'd0);
                    bit_i++;
                end else begin
                    chk("parity_bit", 32'(ser_out), 32'(sb[0].par));
                    chk("frame_end", 32'(frame_end), 32'd1);
                    chk("parity_out", 32'(parity_out), 32'(sb[0].par));
                    void'(sb.pop_front());
                    bit_i       = 0;
                    exp_cnt     = exp_cnt + CW'(1);
                    cnt_pending = 1;
                end
            end else begin
                chk("idle_outputs", {29'd0, ser_out, frame_start, frame_end}, 32'd0);
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    // Present a word; while in_ready=0 keep in_valid high with garbage data
    task automatic send(input logic [DW-1:0] d, input logic odd, input logic par);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            in_valid = 1'b1;
            if (in_ready) begin
                in_data  = d;
                odd_mode = odd;
                sb.push_back('{data: d, par: par});
                done = 1;
            end else begin
                in_data  = DW'($urandom);
                odd_mode = 1'($urandom);
            end
            @(posedge clk); #2;
            guard++;
            if (!done && guard > 40) begin
                chk("accept_timeout", 32'(guard), 32'd0);
                done = 1;
            end
        end
    endtask

    task automatic stop_valid();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        odd_mode = 1'($urandom);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sb.size() != 0 || busy) && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", 32'(guard), 32'd0);
        @(posedge clk); #2;
    endtask

    // Hold reset for one active edge, then check reset state
    task automatic do_reset();
        rst = 1'b1;
        stop_valid();
        @(posedge clk); #2;
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_markers", {30'd0, frame_start, frame_end}, 32'd0);
        chk("rst_ser_out", 32'(ser_out), 32'd0);
        chk("rst_parity_out", 32'(parity_out), 32'd0);
        rst       = 1'b0;
        abort_req = 1;
        @(posedge clk); #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        odd_mode = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        do_reset();

        // Single frames: 0xA5 even/odd, then 0x07 even
        send(8'hA5, 1'b0, 1'b0); stop_valid(); wait_idle();
        chk("frame_cnt_after_1", 32'(frame_cnt), 32'd1);
        chk("run_len_single", 32'(last_run), 32'd9);
        send(8'hA5, 1'b1, 1'b1); stop_valid(); wait_idle();
        send(8'h07, 1'b0, 1'b1); stop_valid(); wait_idle();
        chk("frame_cnt_after_3", 32'(frame_cnt), 32'd3);

        // Backpressure: next word offered during SHIFT with churning data
        send(8'h96, 1'b1, 1'b1);
        send(8'h3B, 1'b0, 1'b1);
        stop_valid(); wait_idle();

        // Reset mid-frame after 4 data bits of 0x3C
        do_reset();
        send(8'h3C, 1'b0, 1'b0);
        stop_valid();
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        chk("abort_ser_valid", 32'(ser_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        rst       = 1'b0;
        abort_req = 1;
        @(posedge clk); #2;
        send(8'h3C, 1'b0, 1'b0); stop_valid(); wait_idle();
        chk("frame_cnt_after_abort", 32'(frame_cnt), 32'd1);

        // Back-to-back: 0x01, 0xFF, 0x00 with in_valid held high
        do_reset();
        send(8'h01, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        stop_valid(); wait_idle();
        chk("b2b_run_len", 32'(last_run), 32'd27);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'd3);

        // Counter wrap with CNT_W=2: expect 1,2,3,0,1
        do_reset();
        send(8'h80, 1'b0, 1'b1); stop_valid(); wait_idle();
        send(8'h5A, 1'b0, 1'b0); stop_valid(); wait_idle();
        send(8'h0F, 1'b1, 1'b1); stop_valid(); wait_idle();
        send(8'h13, 1'b0, 1'b1); stop_valid(); wait_idle();
        chk("wrap_to_zero", 32'(frame_cnt), 32'd0);
        send(8'hC3, 1'b1, 1'b1); stop_valid(); wait_idle();
        chk("wrap_to_one", 32'(frame_cnt), 32'd1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
